// File: rtl/ll_window_detect_pkg.sv
// ll_window_detect_pkg: shared FSM encoding, default widths and the negative-sample clamp.
package ll_window_detect_pkg;
  localparam int LLW_IN_WIDTH = 33;
  localparam int LLW_WIN_LOG2 = 5;
  localparam int SUM_WIDTH = LLW_IN_WIDTH - 1 + LLW_WIN_LOG2;
  localparam logic [1:0] FILL = 2'd0, QUIET = 2'd1, ARMING = 2'd2, ALARM = 2'd3;
  // negative samples (sign bit of a w-bit value) become 0, otherwise keep the low w-1 bits
  function automatic logic [63:0] clamp(input logic [63:0] d, input int w);
    return d[w-1] ? 64'd0 : d & ((64'd1 << (w - 1)) - 64'd1);
  endfunction
endpackage

// File: rtl/ll_win_buf.sv
// ll_win_buf: circular sample buffer; the old entry at addr_i is readable in the same cycle it is overwritten.
module ll_win_buf
  import ll_window_detect_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];
  assign rdata_o = mem[addr_i];
  always_ff @(posedge clk)
    if (we_i) mem[addr_i] <= wdata_i;
endmodule

// File: rtl/ll_window_detect.sv
// ll_window_detect: sliding-window line-length sum/mean with persistence alarm FSM.
// Define LLW_HYST_EN to release the alarm on thresh_lo instead of thresh_hi.
module ll_window_detect
  import ll_window_detect_pkg::*;
#(
  parameter int IN_WIDTH  = LLW_IN_WIDTH,
  parameter int WIN_LOG2  = LLW_WIN_LOG2,
  parameter int ONSET_CNT = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_WIDTH-1:0]          din,
  input  logic                         din_valid,
  input  logic [IN_WIDTH-2:0]          thresh_hi,
  input  logic [IN_WIDTH-2:0]          thresh_lo,
  output logic [IN_WIDTH-2+WIN_LOG2:0] win_sum,
  output logic [IN_WIDTH-2:0]          win_mean,
  output logic                         win_valid,
  output logic                         alarm,
  output logic                         alarm_onset
);
  localparam int XW = IN_WIDTH - 1;
  localparam int SW = XW + WIN_LOG2;
  localparam int WIN_LEN = 2**WIN_LOG2;
  logic [XW-1:0] x, rd;
  logic [WIN_LOG2-1:0] wr_ptr_q;
  logic [WIN_LOG2:0] fill_q;
  logic [SW-1:0] sum_q, sum_d, win_sum_q;
  logic win_valid_q, onset_q, full, last, hi, rel;
  logic [1:0] state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  assign x = XW'(clamp(64'(din), IN_WIDTH));
  assign full = fill_q == (WIN_LOG2 + 1)'(WIN_LEN);
  assign last = fill_q >= (WIN_LOG2 + 1)'(WIN_LEN - 1);
  // stale RAM contents are masked until the window has been filled once
  assign sum_d = sum_q + SW'(x) - (full ? SW'(rd) : '0);
  assign win_sum = win_sum_q;
  assign win_mean = XW'(win_sum_q >> WIN_LOG2);
  assign win_valid = win_valid_q;
  assign alarm = state_q == ALARM;
  assign alarm_onset = onset_q;
  assign hi = win_mean > thresh_hi;
`ifdef LLW_HYST_EN
  assign rel = win_mean < thresh_lo;
`else
  logic unused_thresh_lo;
  assign unused_thresh_lo = ^thresh_lo;
  assign rel = !hi;
`endif
  ll_win_buf #(.DW(XW), .AW(WIN_LOG2)) u_buf (
    .clk     (clk),
    .we_i    (din_valid && rst),
    .addr_i  (wr_ptr_q),
    .wdata_i (x),
    .rdata_o (rd)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == FILL) state_d = full ? QUIET : FILL;
    else if (win_valid_q) begin
      if (state_q == ALARM) begin
        state_d = rel ? QUIET : ALARM;
        cnt_d = rel ? '0 : cnt_q;
      end else if (hi) begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_d == CNT_WIDTH'(ONSET_CNT)) ? ALARM : ARMING;
      end else begin
        state_d = QUIET;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      fill_q <= '0;
      sum_q <= '0;
      win_sum_q <= '0;
      win_valid_q <= 1'b0;
      onset_q <= 1'b0;
      state_q <= FILL;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      onset_q <= state_d == ALARM && state_q != ALARM;
      win_valid_q <= din_valid && last;
      if (din_valid) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        fill_q <= full ? fill_q : fill_q + 1'b1;
        sum_q <= sum_d;
        if (last) win_sum_q <= sum_d;
      end
    end
  end
endmodule
